mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port between the instruction-fetch requester and the data (LWD/SWD) requester of the multicycle CPU.
- Serialises accesses and counts a fixed memory latency. Returns read data, or a write-complete, through a one-cycle ready pulse per requester.
- Sits between the CPU controller/datapath and the memory model. The controller's fetch and memory states stall on the ready pulses instead of counting cycles themselves.

Parameters:
- WORD_SIZE, 16, width of address and data buses.
- MEM_LATENCY, 4, cycles mem_read/mem_write are held per access (range 1..15).
- I_STARVE_LIMIT, 2, consecutive conflict losses after which instruction fetch wins a conflict.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  reset, synchronous, active-low.
- i_req  input  1  instruction read request; held until i_ready.
- i_addr  input  WORD_SIZE  fetch address; sampled at grant.
- i_ready  output  1  one-cycle pulse: i_rdata valid.
- i_rdata  output  WORD_SIZE  fetched word.
- d_req  input  1  data request; held until d_ready.
- d_we  input  1  1 = write, 0 = read; sampled at grant.
- d_addr  input  WORD_SIZE  data address; sampled at grant.
- d_wdata  input  WORD_SIZE  write data; sampled at grant.
- d_ready  output  1  one-cycle pulse: access complete, d_rdata valid for reads.
- d_rdata  output  WORD_SIZE  loaded word.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  WORD_SIZE  memory address.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data; valid in the last strobe cycle.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, BUSY, DONE. Registers:
  - cnt: 4 bits.
  - owner: 0 = I, 1 = D.
  - we_l, addr_l, wdata_l.
  - skip: starvation count, saturating at I_STARVE_LIMIT.
- Reset (reset_n low at posedge, from any state, including mid-access):
  - state becomes IDLE; cnt, owner and skip clear.
  - i_rdata and d_rdata become 0; every output is 0 from the next cycle.
  - The in-flight access is aborted and no ready pulse is issued for it.
- IDLE, arbitration on the sampled i_req/d_req:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D unless skip == I_STARVE_LIMIT, in which case grant I.
  - skip increments when I loses a conflict and clears whenever I is granted.
  - On grant: latch owner, we_l (forced 0 for I), addr_l and wdata_l; set cnt = MEM_LATENCY-1; go to BUSY.
- BUSY:
  - mem_addr = addr_l and mem_wdata = wdata_l.
  - mem_read = !we_l and mem_write = we_l.
  - cnt decrements each cycle.
  - When cnt == 0: for a read, capture mem_rdata into the owner's rdata register; then go to DONE.
  - Requester inputs are ignored while in BUSY, because the access uses the latched copies.
- DONE:
  - Strobes are 0.
  - Pulse the owner's ready for exactly this cycle; the other ready stays 0.
  - Go to IDLE unconditionally.
  - The requester must drop req by the posedge that ends DONE, or a new access is granted in IDLE.
- Latency: a req first sampled in IDLE at cycle 0 gives strobes in cycles 1..MEM_LATENCY and ready in cycle MEM_LATENCY+1.
  - The earliest back-to-back grant is in cycle MEM_LATENCY+2, which leaves one IDLE cycle between accesses.
- rdata registers hold their value until the next read by the same owner. Writes never modify d_rdata.
- Outside BUSY: mem_addr and mem_wdata are 0, and both strobes are 0.
- mem_read and mem_write are never high together. Only one access is ever in flight.
- cnt never wraps. MEM_LATENCY == 1 gives a single BUSY cycle.

Test Plan:
- Lone fetch, L = 4: i_req = 1, i_addr = 0x0010 in cycle 0; memory returns 0x9012 → mem_read = 1 and mem_addr = 0x0010 in cycles 1–4; i_ready = 1 only in cycle 5; i_rdata = 0x9012; d_ready stays 0.
- Conflict: i_req and d_req both rise in cycle 0, with d_addr = 0x0040 read returning 0x1234 → D is served first (d_ready in cycle 5, d_rdata = 0x1234), I is granted in cycle 6, i_ready comes in cycle 11, skip = 0 afterwards.
- Store: d_req = 1, d_we = 1, d_addr = 0x0020, d_wdata = 0xBEEF; d_addr is changed to 0x0099 in cycle 2 → mem_write = 1 with addr 0x0020 and data 0xBEEF in cycles 1–4; mem_read stays 0; d_ready in cycle 5; d_rdata is unchanged.
- Starvation: both requests held continuously, LIMIT = 2 → grant order is D, D, I, D, D, I; skip saturates at 2 and never exceeds it.
- Reset mid-access: reset_n = 0 sampled in cycle 2 of a read → the cycle after is IDLE, strobes = 0, busy = 0, no i_ready/d_ready pulse, rdata = 0; a new request after release completes normally in cycle 5 relative to its grant cycle.
- Back-to-back fetches: i_req is kept high through DONE → the second grant is in cycle 6, second i_ready in cycle 11, with exactly one IDLE cycle in between.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// One access in flight at a time; each completes with a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MEM_LATENCY    = 4,
    parameter int unsigned I_STARVE_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ready,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    localparam int unsigned SkipW = (I_STARVE_LIMIT < 1) ? 1 : $clog2(I_STARVE_LIMIT + 1);
    localparam logic [3:0]       CntInit = 4'(MEM_LATENCY - 1);
    localparam logic [SkipW-1:0] SkipMax = SkipW'(I_STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [SkipW-1:0]     skip_q, skip_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 grant_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            skip_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            skip_q    <= skip_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        skip_d    = skip_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    // Data wins conflicts until fetch has lost SkipMax in a row.
                    grant_d = d_req && !(i_req && (skip_q == SkipMax));
                    if (grant_d) begin
                        owner_d = 1'b1;
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (i_req) begin
                            skip_d = skip_q + 1'b1;
                        end
                    end else begin
                        owner_d = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        skip_d  = '0;
                    end
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_read  = (state_q == StBusy) && !we_q;
        mem_write = (state_q == StBusy) && we_q;
        mem_addr  = (state_q == StBusy) ? addr_q : '0;
        mem_wdata = (state_q == StBusy) ? wdata_q : '0;
        i_ready   = (state_q == StDone) && !owner_q;
        d_ready   = (state_q == StDone) && owner_q;
        busy      = (state_q != StIdle);
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle checks plus a
// per-requester scoreboard of expected read data popped on each ready pulse.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_ready;
    logic [15:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ready;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    logic [15:0] i_exp_q[$];
    logic [15:0] d_exp_q[$];

    mem_port_arbiter #(
        .WORD_SIZE(16),
        .MEM_LATENCY(4),
        .I_STARVE_LIMIT(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ready(i_ready),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ready(d_ready),
        .d_rdata(d_rdata),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h9012;
            16'h0040: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    assign mem_rdata = mem_model(mem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic observe(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic ir, input logic dr, input logic bsy);
        check({tag, "_rd"}, 32'(mem_read), 32'(rd));
        check({tag, "_wr"}, 32'(mem_write), 32'(wr));
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
        check({tag, "_iready"}, 32'(i_ready), 32'(ir));
        check({tag, "_dready"}, 32'(d_ready), 32'(dr));
        check({tag, "_busy"}, 32'(busy), 32'(bsy));
    endtask

    // Scoreboard: every ready pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_excl", 32'(mem_read && mem_write), 32'd0);
            check("ready_excl", 32'(i_ready && d_ready), 32'd0);
            if (i_ready) begin
                if (i_exp_q.size() == 0) check("i_ready_unexpected", 32'd1, 32'd0);
                else check("i_rdata", 32'(i_rdata), 32'(i_exp_q.pop_front()));
            end
            if (d_ready) begin
                if (d_exp_q.size() == 0) check("d_ready_unexpected", 32'd1, 32'd0);
                else check("d_rdata", 32'(d_rdata), 32'(d_exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int last_pulse;
        logic is_d;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        observe("reset", 0, 0, 16'h0, 16'h0, 0, 0, 0);
        check("reset_irdata", 32'(i_rdata), 32'd0);
        check("reset_drdata", 32'(d_rdata), 32'd0);

        // Lone fetch.
        @(negedge clk);
        i_req = 1; i_addr = 16'h0010; i_exp_q.push_back(16'h9012);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            observe($sformatf("fetch_c%0d", k), k <= 4, 0, (k <= 4) ? 16'h0010 : 16'h0,
                    16'h0, k == 5, 0, k <= 5);
            if (k == 5) i_req = 0;
        end

        // Conflict: data first, then fetch.
        i_req = 1; i_addr = 16'h0010; d_req = 1; d_we = 0; d_addr = 16'h0040;
        d_exp_q.push_back(16'h1234); i_exp_q.push_back(16'h9012);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            observe($sformatf("conf_c%0d", k), (k <= 4) || (k >= 7 && k <= 10), 0,
                    (k <= 4) ? 16'h0040 : ((k >= 7 && k <= 10) ? 16'h0010 : 16'h0),
                    16'h0, k == 11, k == 5, (k != 6) && (k != 12));
            if (k == 5) d_req = 0;
            if (k == 11) i_req = 0;
        end

        // Store; address/data changes after grant must not leak through.
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        d_exp_q.push_back(16'h1234);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            observe($sformatf("store_c%0d", k), 0, k <= 4, (k <= 4) ? 16'h0020 : 16'h0,
                    (k <= 4) ? 16'hBEEF : 16'h0, 0, k == 5, k <= 5);
            if (k == 2) begin d_addr = 16'h0099; d_wdata = 16'h1111; end
            if (k == 5) begin d_req = 0; d_we = 0; d_wdata = 16'h0; end
        end

        // Starvation: both held, expect D, D, I repeating, six cycles apart.
        i_req = 1; i_addr = 16'h0010; d_req = 1; d_addr = 16'h0040;
        repeat (4) d_exp_q.push_back(16'h1234);
        repeat (2) i_exp_q.push_back(16'h9012);
        pulses = 0;
        last_pulse = 0;
        for (int k = 1; k <= 100 && pulses < 6; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) begin
                is_d = (pulses % 3) != 2;
                check($sformatf("starve_owner%0d", pulses), 32'(d_ready), 32'(is_d));
                check($sformatf("starve_time%0d", pulses), 32'(k - last_pulse),
                      (pulses == 0) ? 32'd5 : 32'd6);
                last_pulse = k;
                pulses++;
                if (pulses == 6) begin i_req = 0; d_req = 0; end
            end
        end
        check("starve_pulses", 32'(pulses), 32'd6);
        @(negedge clk);

        // Back-to-back fetches with req held through DONE.
        i_req = 1; i_addr = 16'h0010;
        repeat (2) i_exp_q.push_back(16'h9012);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            observe($sformatf("b2b_c%0d", k), (k <= 4) || (k >= 7 && k <= 10), 0,
                    ((k <= 4) || (k >= 7 && k <= 10)) ? 16'h0010 : 16'h0,
                    16'h0, (k == 5) || (k == 11), 0, (k != 6) && (k != 12));
            if (k == 11) i_req = 0;
        end

        // Reset in the middle of a data read aborts it silently.
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                observe($sformatf("rst_c%0d", k), 1, 0, 16'h0040, 16'h0, 0, 0, 1);
            end else begin
                observe($sformatf("rst_c%0d", k), 0, 0, 16'h0, 16'h0, 0, 0, 0);
                check($sformatf("rst_irdata_c%0d", k), 32'(i_rdata), 32'd0);
                check($sformatf("rst_drdata_c%0d", k), 32'(d_rdata), 32'd0);
            end
            if (k == 2) begin reset_n = 0; d_req = 0; end
            if (k == 3) reset_n = 1;
        end
        d_req = 1; d_addr = 16'h0040; d_exp_q.push_back(16'h1234);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            observe($sformatf("post_rst_c%0d", k), k <= 4, 0, (k <= 4) ? 16'h0040 : 16'h0,
                    16'h0, 0, k == 5, k <= 5);
            if (k == 5) d_req = 0;
        end

        repeat (3) @(negedge clk);
        check("i_queue_empty", 32'(i_exp_q.size()), 32'd0);
        check("d_queue_empty", 32'(d_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
